// File: rtl/cmd_receiver.sv
// cmd_receiver
// Ethernet-side command ingress. Receives 32-bit Avalon-ST RX packets in TSE
// layout: 2-byte pad, then ETH/IP/UDP headers, all big-endian. A packet is
// accepted only if its UDP destination port and its first payload word (a
// magic word) match. The command words that follow are staged in a FIFO at a
// tentative write pointer. They become visible only when the packet ends
// cleanly, so a packet is never partially applied. Visible commands drain as
// register writes (addr = cmd[31:24], data = cmd[23:0]).
//
// Ports
//   clk         system clock
//   rst         asynchronous reset, active-high
//   i_rx_data   RX word
//   i_rx_vld    RX word valid
//   i_rx_sop    first word of packet (qualified by i_rx_vld)
//   i_rx_eop    last word of packet (qualified by i_rx_vld)
//   o_rx_rdy    RX ready, held high once out of reset (never backpressures)
//   o_wr_addr   register write address
//   o_wr_data   register write data
//   o_wr_vld    register write request valid
//   i_wr_rdy    register write accepted when o_wr_vld & i_wr_rdy
//   o_pkt_ok    count of committed packets (wraps)
//   o_pkt_drop  count of dropped packets (wraps)

module cmd_receiver #(
  parameter int          HDR_WORDS = 11,
  parameter int          PORT_WORD = 9,
  parameter logic [15:0] UDP_PORT  = 16'd50000,
  parameter logic [31:0] MAGIC     = 32'hC0DE5717,
  parameter int          CMD_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_rx_data,
  input  logic        i_rx_vld,
  input  logic        i_rx_sop,
  input  logic        i_rx_eop,
  output logic        o_rx_rdy,
  output logic [7:0]  o_wr_addr,
  output logic [23:0] o_wr_data,
  output logic        o_wr_vld,
  input  logic        i_wr_rdy,
  output logic [15:0] o_pkt_ok,
  output logic [15:0] o_pkt_drop
);

  localparam int AW = $clog2(CMD_DEPTH);
  localparam int PW = AW + 1;
  localparam int IW = $clog2(HDR_WORDS) + 1;

  localparam logic [IW-1:0] PORT_IDX = IW'(PORT_WORD);
  localparam logic [IW-1:0] LAST_IDX = IW'(HDR_WORDS - 1);
  localparam logic [PW-1:0] DEPTH_PW = PW'(CMD_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_MAGIC,
    S_CMD,
    S_DISCARD
  } state_t;

  state_t        state, state_next;
  logic [IW-1:0] widx, widx_next;
  logic [PW-1:0] wtmp, wtmp_next;
  logic [PW-1:0] wcommit, wcommit_next;
  logic [PW-1:0] rptr;
  logic          rx_rdy;
  logic [15:0]   pkt_ok;
  logic [15:0]   pkt_drop;
  logic [31:0]   mem [CMD_DEPTH];

  logic          rx_fire;
  logic          restart;
  state_t        cur_state;
  logic [IW-1:0] cur_idx;
  logic [PW-1:0] cur_wtmp;
  logic          fifo_full;
  logic          commit;
  logic          drop;
  logic          mem_we;
  logic [1:0]    drop_inc;
  logic [31:0]   rd_word;
  logic          wr_fire;

  // A sop word always starts a fresh packet in HDR at index 0. If a packet
  // was still in progress it is abandoned: its staged commands are rolled
  // back to the last commit point before the sop word is processed, so the
  // same cycle can both drop the old packet and begin the new one.
  always_comb begin
    rx_fire   = i_rx_vld & rx_rdy;
    restart   = rx_fire & i_rx_sop & (state != S_IDLE);
    cur_state = (rx_fire & i_rx_sop) ? S_HDR : state;
    cur_idx   = (rx_fire & i_rx_sop) ? '0 : widx;
    cur_wtmp  = restart ? wcommit : wtmp;
    fifo_full = (cur_wtmp - rptr) >= DEPTH_PW;
  end

  // Next-state logic. Each accepted word is interpreted in the effective
  // state computed above. A command word that finds the FIFO full sends the
  // packet to DISCARD and rolls its staged words back immediately; the drop
  // itself is counted once, at the packet's eop.
  always_comb begin
    state_next   = state;
    widx_next    = widx;
    wtmp_next    = wtmp;
    wcommit_next = wcommit;
    commit       = 1'b0;
    drop         = 1'b0;
    mem_we       = 1'b0;

    if (rx_fire) begin
      state_next = cur_state;
      widx_next  = cur_idx;
      wtmp_next  = cur_wtmp;

      case (cur_state)
        S_IDLE: begin
        end
        S_HDR: begin
          if (i_rx_eop) begin
            drop = 1'b1;
          end else if ((cur_idx == PORT_IDX) && (i_rx_data[15:0] != UDP_PORT)) begin
            state_next = S_DISCARD;
          end else if (cur_idx == LAST_IDX) begin
            state_next = S_MAGIC;
          end else begin
            widx_next = cur_idx + IW'(1);
          end
        end
        S_MAGIC: begin
          if (i_rx_data == MAGIC) begin
            if (i_rx_eop) commit = 1'b1;
            else          state_next = S_CMD;
          end else begin
            if (i_rx_eop) drop = 1'b1;
            else          state_next = S_DISCARD;
          end
        end
        S_CMD: begin
          if (fifo_full) begin
            if (i_rx_eop) begin
              drop = 1'b1;
            end else begin
              state_next = S_DISCARD;
              wtmp_next  = wcommit;
            end
          end else begin
            mem_we    = 1'b1;
            wtmp_next = cur_wtmp + PW'(1);
            if (i_rx_eop) commit = 1'b1;
          end
        end
        S_DISCARD: begin
          if (i_rx_eop) drop = 1'b1;
        end
        default: begin
          state_next = S_IDLE;
        end
      endcase

      if (commit) begin
        wcommit_next = wtmp_next;
        state_next   = S_IDLE;
      end
      if (drop) begin
        wtmp_next  = wcommit;
        state_next = S_IDLE;
      end
    end

    drop_inc = {1'b0, restart} + {1'b0, drop};
  end

  // Output side: only committed entries are visible, read combinationally.
  always_comb begin
    rd_word   = mem[rptr[AW-1:0]];
    o_wr_vld  = (rptr != wcommit);
    o_wr_addr = rd_word[31:24];
    o_wr_data = rd_word[23:0];
    wr_fire   = o_wr_vld & i_wr_rdy;
    o_rx_rdy  = rx_rdy;
    o_pkt_ok  = pkt_ok;
    o_pkt_drop = pkt_drop;
  end

  // State and pointer registers. A commit and a drain in the same cycle
  // touch different pointers, so both take effect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      widx     <= '0;
      wtmp     <= '0;
      wcommit  <= '0;
      rptr     <= '0;
      rx_rdy   <= 1'b0;
      pkt_ok   <= '0;
      pkt_drop <= '0;
    end else begin
      state    <= state_next;
      widx     <= widx_next;
      wtmp     <= wtmp_next;
      wcommit  <= wcommit_next;
      rx_rdy   <= 1'b1;
      if (wr_fire) rptr <= rptr + PW'(1);
      if (commit)  pkt_ok <= pkt_ok + 16'd1;
      pkt_drop <= pkt_drop + 16'(drop_inc);
    end
  end

  // Command storage. Contents need no reset: entries are only readable
  // between rptr and wcommit, and those are always written first.
  always_ff @(posedge clk) begin
    if (mem_we) mem[cur_wtmp[AW-1:0]] <= i_rx_data;
  end

endmodule

// File: tb/tb_cmd_receiver.sv
// Testbench for cmd_receiver. Stimulus builds whole packets as word lists.
// At eop the reference model decides the packet's fate from the packet
// contents and the number of committed-but-undrained commands, and pushes any
// expected writes into a queue. A separate monitor pops and compares every
// write handshake.

module tb_cmd_receiver;

  localparam int          HDR_WORDS = 11;
  localparam int          PORT_WORD = 9;
  localparam logic [15:0] UDP_PORT  = 16'd50000;
  localparam logic [31:0] MAGIC     = 32'hC0DE5717;
  localparam int          DEPTH     = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] i_rx_data = '0;
  logic        i_rx_vld = 1'b0;
  logic        i_rx_sop = 1'b0;
  logic        i_rx_eop = 1'b0;
  logic        o_rx_rdy;
  logic [7:0]  o_wr_addr;
  logic [23:0] o_wr_data;
  logic        o_wr_vld;
  logic        i_wr_rdy = 1'b0;
  logic [15:0] o_pkt_ok;
  logic [15:0] o_pkt_drop;

  int          compared = 0;
  int          mismatched = 0;
  int          pops = 0;
  int          exp_ok = 0;
  int          exp_drop = 0;
  int          rdy_mode = 0;
  logic [31:0] exp_q[$];
  logic [31:0] pkt[$];
  bit          last_full = 1'b1;

  cmd_receiver #(
    .HDR_WORDS(HDR_WORDS),
    .PORT_WORD(PORT_WORD),
    .UDP_PORT (UDP_PORT),
    .MAGIC    (MAGIC),
    .CMD_DEPTH(DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_rx_data (i_rx_data),
    .i_rx_vld  (i_rx_vld),
    .i_rx_sop  (i_rx_sop),
    .i_rx_eop  (i_rx_eop),
    .o_rx_rdy  (o_rx_rdy),
    .o_wr_addr (o_wr_addr),
    .o_wr_data (o_wr_data),
    .o_wr_vld  (o_wr_vld),
    .i_wr_rdy  (i_wr_rdy),
    .o_pkt_ok  (o_pkt_ok),
    .o_pkt_drop(o_pkt_drop)
  );

  always #5 clk = ~clk;

  // Compares one value and reports a mismatch.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives i_wr_rdy: 0 = held low, 1 = held high, 2 = random.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 2) i_wr_rdy = 1'($urandom_range(0, 1));
      else               i_wr_rdy = (rdy_mode == 1);
    end
  end

  // Monitor: every write handshake must match the oldest expected command.
  always @(negedge clk) begin
    if (!rst && o_wr_vld && i_wr_rdy) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_write: got 0x%0h, expected no write", {o_wr_addr, o_wr_data});
      end else begin
        checkOutput("write", {o_wr_addr, o_wr_data}, exp_q.pop_front());
        pops++;
      end
    end
  end

  // Builds a header (with the given port), the magic word and random commands.
  task automatic build_pkt(input logic [15:0] port, input logic [31:0] magic, input int ncmds);
    logic [31:0] w;
    pkt.delete();
    for (int i = 0; i < HDR_WORDS; i++) begin
      w = $urandom;
      if (i == PORT_WORD) w[15:0] = port;
      pkt.push_back(w);
    end
    pkt.push_back(magic);
    for (int i = 0; i < ncmds; i++) pkt.push_back($urandom);
  endtask

  // Reference model: a packet commits when it holds a full header, the right
  // port, the magic word, and all its commands fit beside undrained ones.
  task automatic model_eop();
    bit          good;
    logic [31:0] pw;
    int          ncmd;
    good = 1'b0;
    if (pkt.size() >= HDR_WORDS + 1) begin
      pw   = pkt[PORT_WORD];
      ncmd = pkt.size() - HDR_WORDS - 1;
      good = (pw[15:0] == UDP_PORT) && (pkt[HDR_WORDS] == MAGIC) &&
             (exp_q.size() + ncmd <= DEPTH);
    end
    if (good) begin
      exp_ok++;
      for (int i = HDR_WORDS + 1; i < pkt.size(); i++) exp_q.push_back(pkt[i]);
    end else begin
      exp_drop++;
    end
  endtask

  // Sends the first nsend words of pkt; eop only if the whole packet is sent.
  task automatic applyStimulus(input int nsend, input bit gaps, input bit chk_lat);
    bit full;
    full = (nsend == pkt.size());
    for (int i = 0; i < nsend; i++) begin
      if (gaps && i > 0 && $urandom_range(0, 3) == 0) begin
        i_rx_vld = 1'b0;
        i_rx_sop = 1'b0;
        i_rx_eop = 1'b0;
        @(posedge clk);
        #1;
      end
      i_rx_vld  = 1'b1;
      i_rx_sop  = (i == 0);
      i_rx_eop  = full && (i == nsend - 1);
      i_rx_data = pkt[i];
      if (i_rx_eop) begin
        if (chk_lat) checkOutput("wr_vld_before_eop", 32'(o_wr_vld), 32'd0);
        model_eop();
      end
      @(posedge clk);
      #1;
    end
    i_rx_vld = 1'b0;
    i_rx_sop = 1'b0;
    i_rx_eop = 1'b0;
    if (chk_lat) checkOutput("wr_vld_after_eop", 32'(o_wr_vld), 32'd1);
    if (!full) exp_drop++;
    last_full = full;
  endtask

  task automatic check_counters(input string tag);
    checkOutput({tag, "_pkt_ok"}, 32'(o_pkt_ok), 32'(16'(exp_ok)));
    checkOutput({tag, "_pkt_drop"}, 32'(o_pkt_drop), 32'(16'(exp_drop)));
  endtask

  // Drains all expected writes with wr_rdy held high, then checks nothing is left.
  task automatic wait_drain(input string tag);
    int budget;
    rdy_mode = 1;
    budget = 500;
    while (exp_q.size() != 0 && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
    end
    if (budget == 0) checkOutput({tag, "_drain_timeout"}, 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    checkOutput({tag, "_fifo_empty"}, 32'(o_wr_vld), 32'd0);
  endtask

  task automatic wait_space(input int need);
    int budget;
    budget = 2000;
    while (exp_q.size() + need > DEPTH && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
    end
    if (budget == 0) checkOutput("space_timeout", 32'(exp_q.size()), 32'(DEPTH - need));
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    i_rx_vld = 1'b0;
    i_rx_sop = 1'b0;
    i_rx_eop = 1'b0;
    exp_q.delete();
    exp_ok = 0;
    exp_drop = 0;
    last_full = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput({tag, "_rst_rx_rdy"}, 32'(o_rx_rdy), 32'd0);
    checkOutput({tag, "_rst_wr_vld"}, 32'(o_wr_vld), 32'd0);
    checkOutput({tag, "_rst_pkt_ok"}, 32'(o_pkt_ok), 32'd0);
    checkOutput({tag, "_rst_pkt_drop"}, 32'(o_pkt_drop), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput({tag, "_rx_rdy_up"}, 32'(o_rx_rdy), 32'd1);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int p0;
    int kind;
    int ncmds;
    int len;
    logic [15:0] port;
    logic [31:0] magic;

    // Good packet, three commands, immediate drain.
    do_reset("t1");
    rdy_mode = 1;
    build_pkt(UDP_PORT, MAGIC, 0);
    pkt.push_back(32'h01000123);
    pkt.push_back(32'h02000456);
    pkt.push_back(32'h03000789);
    p0 = pops;
    applyStimulus(pkt.size(), 1'b0, 1'b1);
    wait_drain("t1");
    checkOutput("t1_write_count", 32'(pops - p0), 32'd3);
    check_counters("t1");

    // Wrong UDP port.
    do_reset("t2");
    rdy_mode = 1;
    build_pkt(16'd50001, MAGIC, 3);
    applyStimulus(pkt.size(), 1'b0, 1'b0);
    wait_drain("t2");
    check_counters("t2");

    // Bad magic word.
    do_reset("t3");
    rdy_mode = 1;
    build_pkt(UDP_PORT, 32'hDEADBEEF, 3);
    applyStimulus(pkt.size(), 1'b0, 1'b0);
    wait_drain("t3");
    check_counters("t3");

    // Fill the FIFO exactly, then overflow with a one-command packet.
    do_reset("t4");
    rdy_mode = 0;
    build_pkt(UDP_PORT, MAGIC, 16);
    applyStimulus(pkt.size(), 1'b1, 1'b0);
    build_pkt(UDP_PORT, MAGIC, 1);
    applyStimulus(pkt.size(), 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check_counters("t4");
    checkOutput("t4_held_vld", 32'(o_wr_vld), 32'd1);
    p0 = pops;
    wait_drain("t4");
    checkOutput("t4_write_count", 32'(pops - p0), 32'd16);

    // Packet A cut short by the sop of valid packet B.
    do_reset("t5");
    rdy_mode = 1;
    build_pkt(UDP_PORT, MAGIC, 2);
    applyStimulus(pkt.size() - 1, 1'b0, 1'b0);
    build_pkt(UDP_PORT, MAGIC, 0);
    pkt.push_back(32'h0500000A);
    p0 = pops;
    applyStimulus(pkt.size(), 1'b0, 1'b0);
    wait_drain("t5");
    checkOutput("t5_write_count", 32'(pops - p0), 32'd1);
    check_counters("t5");

    // Reset in the middle of a packet, then a clean packet.
    rdy_mode = 1;
    build_pkt(UDP_PORT, MAGIC, 3);
    applyStimulus(13, 1'b0, 1'b0);
    do_reset("t6");
    build_pkt(UDP_PORT, MAGIC, 1);
    p0 = pops;
    applyStimulus(pkt.size(), 1'b1, 1'b0);
    wait_drain("t6");
    checkOutput("t6_write_count", 32'(pops - p0), 32'd1);
    check_counters("t6");

    // Randomized traffic with random write backpressure.
    do_reset("rnd");
    rdy_mode = 2;
    for (int n = 0; n < 80; n++) begin
      kind  = $urandom_range(0, 9);
      ncmds = $urandom_range(0, 6);
      port  = UDP_PORT;
      magic = MAGIC;
      if (kind == 0) port = UDP_PORT + 16'($urandom_range(1, 100));
      if (kind == 1) magic = MAGIC ^ (32'd1 << $urandom_range(0, 31));
      if (last_full && $urandom_range(0, 3) == 0) begin
        i_rx_vld  = 1'b1;
        i_rx_data = $urandom;
        @(posedge clk);
        #1;
        i_rx_vld = 1'b0;
      end
      wait_space(ncmds);
      build_pkt(port, magic, ncmds);
      if (kind == 2) begin
        len = $urandom_range(1, HDR_WORDS);
        while (pkt.size() > len) void'(pkt.pop_back());
      end
      if (kind == 3) applyStimulus($urandom_range(1, pkt.size() - 1), 1'b1, 1'b0);
      else           applyStimulus(pkt.size(), 1'b1, 1'b0);
    end
    if (!last_full) begin
      build_pkt(UDP_PORT, MAGIC, 2);
      wait_space(2);
      applyStimulus(pkt.size(), 1'b0, 1'b0);
    end
    wait_drain("rnd");
    check_counters("rnd");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
